// File: rtl/edge_byte_packer.sv
// Packs a 1-bit edge pixel stream MSB-first into bytes, zero-padding each line's
// final byte. Bytes are buffered in a small FIFO behind a valid/ready interface.
module edge_byte_packer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          edge_bin,
    input  logic                          valid_in,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_eol,
    output logic                          out_last,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [LW-1:0]    LEVEL_FULL = LW'(FIFO_DEPTH);

    // Pixel packing state
    logic [6:0]       sr_r;
    logic [2:0]       bit_cnt_r;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    // FIFO state; entries are {last, eol, data}
    logic [9:0]       mem_r [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             overflow_r;
    logic             frame_done_r;

    logic             line_end_s;
    logic             push_s;
    logic [7:0]       push_data_s;
    logic             push_last_s;
    logic [9:0]       head_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             wr_en_s;
    logic             drop_s;

    // Byte completion and FIFO handshake decode
    always_comb begin
        line_end_s  = (col_r == COL_LAST);
        push_s      = valid_in & ((bit_cnt_r == 3'd7) | line_end_s);
        // Left-justify a short final group so the unused LSBs are zero
        push_data_s = {sr_r, edge_bin} << (3'd7 - bit_cnt_r);
        push_last_s = line_end_s & (row_r == ROW_LAST);
        head_s      = mem_r[rd_ptr_r];
        empty_s     = (level_r == {LW{1'b0}});
        full_s      = (level_r == LEVEL_FULL);
        pop_s       = ~empty_s & out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        wr_en_s     = push_s & (~full_s | pop_s);
        drop_s      = push_s & full_s & ~pop_s;
    end

    // Shift register, group bit counter and raster position
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r      <= 7'd0;
            bit_cnt_r <= 3'd0;
            col_r     <= {COL_W{1'b0}};
            row_r     <= {ROW_W{1'b0}};
        end else if (valid_in) begin
            sr_r      <= {sr_r[5:0], edge_bin};
            bit_cnt_r <= push_s ? 3'd0 : (bit_cnt_r + 3'd1);
            if (line_end_s) begin
                col_r <= {COL_W{1'b0}};
                row_r <= (row_r == ROW_LAST) ? {ROW_W{1'b0}} : (row_r + ROW_W'(1));
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            sr_r      <= sr_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // FIFO storage array; contents are don't-care while the level says empty
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= {push_last_s, line_end_s, push_data_s};
        end
    end

    // FIFO pointers, occupancy, sticky overflow and frame completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= {LW{1'b0}};
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            overflow_r   <= overflow_r | drop_s;
            frame_done_r <= pop_s & head_s[9];
        end
    end

    assign out_valid  = ~empty_s;
    assign out_data   = empty_s ? 8'd0 : head_s[7:0];
    assign out_eol    = ~empty_s & head_s[8];
    assign out_last   = ~empty_s & head_s[9];
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_edge_byte_packer.sv
// Randomized bench for edge_byte_packer checked every cycle against a queue-based
// model of line/byte grouping and FIFO occupancy, plus directed scenario checks.
module tb_edge_byte_packer;

    localparam int IMG_W = 10;
    localparam int IMG_H = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       edge_bin;
    logic       valid_in;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_eol;
    logic       out_last;
    logic       frame_done;
    logic       overflow;
    logic [2:0] fifo_level;

    edge_byte_packer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .edge_bin(edge_bin), .valid_in(valid_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_eol(out_eol), .out_last(out_last), .frame_done(frame_done),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int         m_col = 0;
    int         m_row = 0;
    int         grp[$];
    logic [9:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_fd  = 1'b0;
    logic [9:0] acc[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input bit r, input bit v, input bit e, input bit rdy);
        logic [9:0] head;
        logic [31:0] b;
        bit eol;
        bit last;
        rst = r; valid_in = v; edge_bin = e; out_ready = rdy;
        if (!r && out_valid === 1'b1 && rdy) acc.push_back({out_last, out_eol, out_data});
        @(posedge clk);
        #1;
        if (r) begin
            m_col = 0; m_row = 0; grp.delete(); mq.delete(); m_ovf = 1'b0; m_fd = 1'b0;
        end else begin
            m_fd = 1'b0;
            if (mq.size() != 0 && rdy) begin
                head = mq.pop_front();
                m_fd = head[9];
            end
            if (v) begin
                grp.push_back(int'(e));
                eol = (m_col == IMG_W - 1);
                if (grp.size() == 8 || eol) begin
                    b = 32'd0;
                    foreach (grp[i]) b = b | (32'(grp[i]) << (7 - i));
                    last = eol && (m_row == IMG_H - 1);
                    if (mq.size() < DEPTH) mq.push_back({last, eol, b[7:0]});
                    else m_ovf = 1'b1;
                    grp.delete();
                end
                if (eol) begin
                    m_col = 0;
                    m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_eq("out_data", 32'(out_data), 32'(mq[0][7:0]));
            check_eq("out_eol", 32'(out_eol), 32'(mq[0][8]));
            check_eq("out_last", 32'(out_last), 32'(mq[0][9]));
        end
        check_eq("fifo_level", 32'(fifo_level), 32'(mq.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    logic [9:0] line0;
    logic [9:0] exp_bytes [4];

    initial begin
        line0 = 10'b1011001011;
        exp_bytes[0] = 10'h0B2; exp_bytes[1] = 10'h1C0;
        exp_bytes[2] = 10'h0FF; exp_bytes[3] = 10'h3C0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("rst_data", 32'(out_data), 32'h0);
        check_eq("rst_eol", 32'(out_eol), 32'h0);
        check_eq("rst_last", 32'(out_last), 32'h0);

        // Directed frame: known line then all-ones line
        acc.delete();
        for (int i = 0; i < IMG_W; i++) step(1'b0, 1'b1, line0[9-i], 1'b1);
        for (int i = 0; i < IMG_W; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("dir_count", 32'(acc.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq("dir_byte", (i < acc.size()) ? 32'(acc[i]) : 32'hFFFF, 32'(exp_bytes[i]));
        for (int i = 0; i < IMG_W; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b1);

        // Overflow with stalled output, then drain
        step(1'b1, 1'b0, 1'b0, 1'b0);
        acc.delete();
        for (int i = 0; i < 48; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0);
        check_eq("ovf_level", 32'(fifo_level), 32'd4);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("drain_count", 32'(acc.size()), 32'd4);

        // Output ready toggling with continuous pixels
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'(i % 2 == 0));

        // Full FIFO with simultaneous pop and push
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 27; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("full_pp_level", 32'(fifo_level), 32'd4);
        check_eq("full_pp_ovf", 32'(overflow), 32'd0);

        // Reset mid-line with bytes queued
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_level", 32'(fifo_level), 32'd0);
        check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("post_rst_data", 32'(out_data), 32'hFF);
        check_eq("post_rst_eol", 32'(out_eol), 32'd0);

        // Input gaps: one pixel every third cycle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < IMG_W; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Long random run with mixed ready bias and occasional reset
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 400; i++)
                step(1'($urandom_range(199) == 0), 1'($urandom_range(2) != 0),
                     1'($urandom_range(1)), 1'($urandom_range(4) < p + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
